idct_systolic_col: RTL and testbench
====================================

// Module: idct_systolic_col
// PURPOSE
//  Parametrised N-tap IDCT column engine: d_out = sat(round(sum_k coef[k]*x[k]) >>> shift).
//  Accepts one aligned coefficient-vector input per cycle, skews lanes internally and
//  accumulates along a registered transposed adder chain. Forwards inputs for chaining.
//  Adds valid/stall/clear control, programmable coefficients, internal rounding and saturation.
// PARAMETERS
//  DW        25                 input lane width, signed
//  N         4                  taps/lanes, 2..16
//  CW        8                  coefficient width, signed
//  OW        16                 output width, signed; OW <= AW
//  SW        5                  shift-amount width
//  COEF_INIT {83,-64,-36,64}    packed N*CW reset coefficients; lane 0 in LSBs
// PORTS
//  clk        in   1       clock
//  reset      in   1       asynchronous, active-high
//  clr        in   1       sync flush of pipeline
//  stall      in   1       freeze datapath and valid pipe
//  in_valid   in   1       d_in/shift/rnd_en valid this cycle
//  d_in       in   N*DW    lane k at [k*DW +: DW]
//  shift      in   SW      right-shift amount, carried with vector
//  rnd_en     in   1       add 1<<(shift-1) before shift (shift>0)
//  coef_we    in   1       coefficient write strobe
//  coef_idx   in   clog2N  lane to write
//  coef_wdata in   CW      coefficient value
//  d_out      out  OW      saturated result
//  out_valid  out  1       d_out valid, one pulse per vector
//  sat_flag   out  1       qualified with out_valid: result clamped
//  d_fwd      out  N*DW    d_in registered once
//  fwd_valid  out  1       in_valid registered once
//  busy       out  1       any valid vector in pipeline
// BEHAVIOUR
//  - reset: all outputs 0; coef regs <= COEF_INIT; valid pipe empty.
//  - Latency N+1 cycles, throughput 1/cycle. Accept at edge t -> out_valid at edge t+N+1.
//  - Stage 0 at t+1: p0 = x0*c0. Stage k at t+k+1: pk = p(k-1) + x_k*c_k.
//    x_k is delayed k cycles; shift/rnd_en travel with the vector.
//  - Output stage at t+N+1 applies round, arithmetic shift, clamp and registers the result.
//  - Widths: product DW+CW; accumulator AW = DW+CW+clog2(N), sign-extended, no wrap.
//  - Rounding: acc + (rnd_en && shift!=0 ? 1<<(shift-1) : 0), then >>> shift (floor).
//  - Saturation to [-2^(OW-1), 2^(OW-1)-1]; sat_flag=1 when clamped, else 0.
//  - stall=1 holds every pipeline reg, d_fwd and fwd_valid; out_valid=0 during stall.
//    The pending result presents one cycle after stall drops; in_valid ignored while stalled.
//  - clr=1: valid pipe, partial sums, out_valid, fwd_valid, sat_flag cleared; d_out <= 0.
//    Coefficient regs are kept. clr beats in_valid and stall in the same cycle.
//  - coef_we writes at the edge regardless of stall/clr; visible to products formed from next cycle.
//    Writes while busy=1 are legal: each lane uses the coefficient current when its product is formed.
//  - coef_idx >= N: write ignored.
//  - reset mid-operation: all in-flight vectors lost, no out_valid until new input.
//  - busy = OR of valid pipe stages (combinational from regs).
// STRUCTURE
//  - idct_pkg: HEVC coefficient constants (64,83,36,89,75,50,18), default COEF_INIT
//    for N=4/8, clog2 function, AW computation.
//  - Sub-module idct_mac_stage: lane delay line + multiply + add + partial-sum reg
//    with stall/clr; instantiated N times via generate.
//  - Top: coef bank, valid/shift/rnd pipe, output round/shift/saturate stage, forward regs.
// TESTING
//  1. Reset, N=4 defaults, d_in={1,1,1,1}, shift=0 -> d_out=47 exactly 5 cycles later, single out_valid.
//  2. Back-to-back unit vectors e0,e1,e2,e3 -> d_out 64,-36,-64,83 on 4 consecutive cycles.
//  3. x0=100, shift=7, rnd_en=1 -> d_out=50; x0=-100 -> d_out=-50; rnd_en=0 and x0=100 -> 50.
//  4. OW=16, x0=x3=1000 -> d_out=32767, sat_flag=1; x0=x3=-1000 -> d_out=-32768, sat_flag=1.
//  5. Stall 3 cycles with 2 vectors in flight -> results unchanged, each delayed 3 cycles; d_fwd held.
//  6. Write coef[3]=89, x={1,1,1,1} -> 53; clr with vector in flight -> no out_valid, busy=0 next cycle.

Source files
------------

// File: rtl/idct_systolic_col_pkg.sv
// Shared constants and width helpers for the systolic IDCT column engine.
// Holds HEVC basis coefficients, default coefficient vectors and accumulator sizing.
package idct_pkg;

   localparam int C64 = 64;
   localparam int C83 = 83;
   localparam int C36 = 36;
   localparam int C89 = 89;
   localparam int C75 = 75;
   localparam int C50 = 50;
   localparam int C18 = 18;

   // Lane 0 in the LSBs: lanes {64, -36, -64, 83}
   localparam logic [31:0] COEF_INIT_N4 = {8'(C83), 8'(-C64), 8'(-C36), 8'(C64)};

   // Odd basis row of the 8-point transform, lane 0 = 89
   localparam logic [63:0] COEF_INIT_N8 = {8'(-C89), 8'(-C75), 8'(-C50), 8'(-C18),
                                           8'(C18), 8'(C50), 8'(C75), 8'(C89)};

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cw,
                                             input int unsigned n);
      return dw + cw + clog2(n);
   endfunction

endpackage

// File: rtl/idct_systolic_col_if.sv
// Data, control and coefficient-write signals of the IDCT column engine.
// master drives vectors and control; slave is the engine.
interface idct_systolic_col_if
   import idct_pkg::*;
#(
   parameter int unsigned DW = 25,
   parameter int unsigned N  = 4,
   parameter int unsigned CW = 8,
   parameter int unsigned OW = 16,
   parameter int unsigned SW = 5
);
   localparam int unsigned IW = clog2(N);

   logic                 clr;
   logic                 stall;
   logic                 in_valid;
   logic [N*DW-1:0]      d_in;
   logic [SW-1:0]        shift;
   logic                 rnd_en;
   logic                 coef_we;
   logic [IW-1:0]        coef_idx;
   logic signed [CW-1:0] coef_wdata;
   logic signed [OW-1:0] d_out;
   logic                 out_valid;
   logic                 sat_flag;
   logic [N*DW-1:0]      d_fwd;
   logic                 fwd_valid;
   logic                 busy;

   modport master (
      output clr, stall, in_valid, d_in, shift, rnd_en, coef_we, coef_idx, coef_wdata,
      input  d_out, out_valid, sat_flag, d_fwd, fwd_valid, busy
   );

   modport slave (
      input  clr, stall, in_valid, d_in, shift, rnd_en, coef_we, coef_idx, coef_wdata,
      output d_out, out_valid, sat_flag, d_fwd, fwd_valid, busy
   );

endinterface

// File: rtl/idct_systolic_col_mac_stage.sv
// One systolic lane: DLY-deep input skew line, multiply by the live coefficient,
// add the upstream partial sum and register it.
module idct_mac_stage #(
   parameter int unsigned DW  = 25,
   parameter int unsigned CW  = 8,
   parameter int unsigned AW  = 35,
   parameter int unsigned DLY = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 clr,
   input  logic signed [DW-1:0] x,
   input  logic signed [CW-1:0] coef,
   input  logic signed [AW-1:0] psum_in,
   output logic signed [AW-1:0] psum_out
);

   logic signed [DW-1:0]    x_dly;
   logic signed [DW+CW-1:0] prod;
   logic signed [AW-1:0]    psum_q;

   if (DLY == 0) begin : g_nodly
      assign x_dly = x;
   end else begin : g_dly
      logic signed [DW-1:0] dly_q [DLY];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
         end else if (!stall) begin
            dly_q[0] <= x;
            for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
         end
      end

      assign x_dly = dly_q[DLY-1];
   end

   assign prod = x_dly * coef;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psum_q <= '0;
      end else if (clr) begin
         psum_q <= '0;
      end else if (!stall) begin
         psum_q <= psum_in + {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
      end
   end

   assign psum_out = psum_q;

endmodule

// File: rtl/idct_systolic_col.sv
// N-tap IDCT column engine: skewed lanes feed a registered adder chain, then a
// round / arithmetic-shift / saturate output stage. Inputs are forwarded for chaining.
module idct_systolic_col
   import idct_pkg::*;
#(
   parameter int unsigned    DW        = 25,
   parameter int unsigned    N         = 4,
   parameter int unsigned    CW        = 8,
   parameter int unsigned    OW        = 16,
   parameter int unsigned    SW        = 5,
   parameter logic [N*CW-1:0] COEF_INIT = COEF_INIT_N4
) (
   input logic               clk,
   input logic               reset,
   idct_systolic_col_if.slave bus
);

   localparam int unsigned AW = acc_width(DW, CW, N);
   localparam int unsigned IW = clog2(N);

   localparam logic signed [AW:0] OMAX = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW:0] OMIN = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

   logic signed [CW-1:0] coef_q [N];
   logic [N*DW-1:0]      d_fwd_q;
   logic                 fwd_valid_q;
   logic [SW-1:0]        sh_in_q;
   logic                 rnd_in_q;
   logic [N-1:0]         vld_q;
   logic [N-1:0]         rnd_q;
   logic [SW-1:0]        sh_q [N];
   logic signed [AW-1:0] psum [N];
   logic signed [OW-1:0] d_out_q;
   logic                 out_valid_q;
   logic                 sat_q;

   // Writes land regardless of stall/clr; out-of-range lanes match no entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N; k++) coef_q[k] <= COEF_INIT[k*CW +: CW];
      end else if (bus.coef_we) begin
         for (int k = 0; k < N; k++) begin
            if (bus.coef_idx == IW'(k)) coef_q[k] <= bus.coef_wdata;
         end
      end
   end

   // Forward register doubles as the input capture stage of the pipeline
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_fwd_q     <= '0;
         fwd_valid_q <= 1'b0;
         sh_in_q     <= '0;
         rnd_in_q    <= 1'b0;
      end else if (bus.clr) begin
         fwd_valid_q <= 1'b0;
      end else if (!bus.stall) begin
         d_fwd_q     <= bus.d_in;
         fwd_valid_q <= bus.in_valid;
         sh_in_q     <= bus.shift;
         rnd_in_q    <= bus.rnd_en;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         rnd_q <= '0;
         for (int k = 0; k < N; k++) sh_q[k] <= '0;
      end else if (bus.clr) begin
         vld_q <= '0;
      end else if (!bus.stall) begin
         vld_q   <= {vld_q[N-2:0], fwd_valid_q};
         rnd_q   <= {rnd_q[N-2:0], rnd_in_q};
         sh_q[0] <= sh_in_q;
         for (int k = 1; k < N; k++) sh_q[k] <= sh_q[k-1];
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_lane
      logic signed [AW-1:0] chain_in;

      if (k == 0) begin : g_first
         assign chain_in = '0;
      end else begin : g_next
         assign chain_in = psum[k-1];
      end

      idct_mac_stage #(
         .DW  (DW),
         .CW  (CW),
         .AW  (AW),
         .DLY (k)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .stall    (bus.stall),
         .clr      (bus.clr),
         .x        (d_fwd_q[k*DW +: DW]),
         .coef     (coef_q[k]),
         .psum_in  (chain_in),
         .psum_out (psum[k])
      );
   end

   logic signed [AW:0]   acc_ext;
   logic signed [AW:0]   rnd_add;
   logic signed [AW:0]   rounded;
   logic signed [AW:0]   shifted;
   logic signed [OW-1:0] res;
   logic                 res_sat;

   always_comb begin
      acc_ext = {psum[N-1][AW-1], psum[N-1]};
      rnd_add = '0;
      if (rnd_q[N-1] && (sh_q[N-1] != '0)) begin
         rnd_add = (AW+1)'(1) << (sh_q[N-1] - SW'(1));
      end
      rounded = acc_ext + rnd_add;
      shifted = rounded >>> sh_q[N-1];
      res     = shifted[OW-1:0];
      res_sat = 1'b0;
      if (shifted > OMAX) begin
         res     = OMAX[OW-1:0];
         res_sat = 1'b1;
      end else if (shifted < OMIN) begin
         res     = OMIN[OW-1:0];
         res_sat = 1'b1;
      end
   end

   // A stalled edge drops out_valid so the held result is not presented twice
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_out_q     <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else if (bus.clr) begin
         d_out_q     <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else if (bus.stall) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= vld_q[N-1];
         if (vld_q[N-1]) begin
            d_out_q <= res;
            sat_q   <= res_sat;
         end
      end
   end

   assign bus.d_out     = d_out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sat_flag  = sat_q;
   assign bus.d_fwd     = d_fwd_q;
   assign bus.fwd_valid = fwd_valid_q;
   assign bus.busy      = fwd_valid_q | (|vld_q);

endmodule

// File: tb/tb_idct_systolic_col.sv
// Directed bench for idct_systolic_col with the default N=4 configuration;
// expected values are hand-computed from the default and rewritten coefficients.
module tb_idct_systolic_col;

   localparam int unsigned DW = 25;
   localparam int unsigned N  = 4;
   localparam int unsigned CW = 8;
   localparam int unsigned OW = 16;
   localparam int unsigned SW = 5;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   idct_systolic_col_if #(.DW(DW), .N(N), .CW(CW), .OW(OW), .SW(SW)) bus ();

   idct_systolic_col #(.DW(DW), .N(N), .CW(CW), .OW(OW), .SW(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int x0, input int x1, input int x2, input int x3);
      bus.d_in = {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
   endtask

   task automatic put(input int x0, input int x1, input int x2, input int x3,
                      input int sh, input logic rnd);
      set_vec(x0, x1, x2, x3);
      bus.shift    = SW'(sh);
      bus.rnd_en   = rnd;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.d_in     = '0;
      bus.shift    = '0;
      bus.rnd_en   = 1'b0;
   endtask

   task automatic run1(input string tag, input int x0, input int x1, input int x2,
                       input int x3, input int sh, input logic rnd,
                       input longint exp, input longint exp_sat);
      put(x0, x1, x2, x3, sh, rnd);
      repeat (4) tick();
      check({tag, "_early"}, longint'(bus.out_valid), 0);
      tick();
      check({tag, "_valid"}, longint'(bus.out_valid), 1);
      check({tag, "_dout"}, longint'($signed(bus.d_out)), exp);
      check({tag, "_sat"}, longint'(bus.sat_flag), exp_sat);
   endtask

   function automatic longint lane(input logic [N*DW-1:0] v, input int k);
      logic signed [DW-1:0] s;
      s = v[k*DW +: DW];
      return longint'(s);
   endfunction

   initial begin
      logic seen;
      n_checks       = 0;
      n_fail         = 0;
      reset          = 1'b1;
      bus.clr        = 1'b0;
      bus.stall      = 1'b0;
      bus.in_valid   = 1'b0;
      bus.d_in       = '0;
      bus.shift      = '0;
      bus.rnd_en     = 1'b0;
      bus.coef_we    = 1'b0;
      bus.coef_idx   = '0;
      bus.coef_wdata = '0;
      repeat (2) tick();
      check("rst_dout", longint'($signed(bus.d_out)), 0);
      check("rst_out_valid", longint'(bus.out_valid), 0);
      check("rst_busy", longint'(bus.busy), 0);
      check("rst_fwd_valid", longint'(bus.fwd_valid), 0);
      reset = 1'b0;
      tick();

      // 1: all-ones vector, exact latency and single pulse
      put(1, 1, 1, 1, 0, 1'b0);
      check("t1_fwd_valid", longint'(bus.fwd_valid), 1);
      check("t1_fwd_lane2", lane(bus.d_fwd, 2), 1);
      check("t1_busy", longint'(bus.busy), 1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("t1_no_early_valid", longint'(bus.out_valid), 0);
      end
      tick();
      check("t1_valid", longint'(bus.out_valid), 1);
      check("t1_dout", longint'($signed(bus.d_out)), 47);
      check("t1_sat", longint'(bus.sat_flag), 0);
      check("t1_busy_done", longint'(bus.busy), 0);
      tick();
      check("t1_single_pulse", longint'(bus.out_valid), 0);

      // 2: back-to-back unit vectors
      put(1, 0, 0, 0, 0, 1'b0);
      put(0, 1, 0, 0, 0, 1'b0);
      put(0, 0, 1, 0, 0, 1'b0);
      put(0, 0, 0, 1, 0, 1'b0);
      tick();
      tick();
      check("t2_v0", longint'(bus.out_valid), 1);
      check("t2_e0", longint'($signed(bus.d_out)), 64);
      tick();
      check("t2_v1", longint'(bus.out_valid), 1);
      check("t2_e1", longint'($signed(bus.d_out)), -36);
      tick();
      check("t2_v2", longint'(bus.out_valid), 1);
      check("t2_e2", longint'($signed(bus.d_out)), -64);
      tick();
      check("t2_v3", longint'(bus.out_valid), 1);
      check("t2_e3", longint'($signed(bus.d_out)), 83);
      tick();
      check("t2_end", longint'(bus.out_valid), 0);

      // 3: rounding and floor shift
      run1("t3_pos_rnd", 100, 0, 0, 0, 7, 1'b1, 50, 0);
      run1("t3_neg_rnd", -100, 0, 0, 0, 7, 1'b1, -50, 0);
      run1("t3_pos_nornd", 100, 0, 0, 0, 7, 1'b0, 50, 0);

      // 4: saturation both ways
      run1("t4_sat_hi", 1000, 0, 0, 1000, 0, 1'b0, 32767, 1);
      run1("t4_sat_lo", -1000, 0, 0, -1000, 0, 1'b0, -32768, 1);

      // 5: stall for 3 edges with two vectors in flight; input during stall ignored
      put(1, 1, 1, 1, 0, 1'b0);
      put(0, 0, 0, 1, 0, 1'b0);
      bus.stall    = 1'b1;
      bus.in_valid = 1'b1;
      set_vec(7, 7, 7, 7);
      repeat (3) begin
         tick();
         check("t5_stall_no_valid", longint'(bus.out_valid), 0);
      end
      check("t5_fwd_lane0_held", lane(bus.d_fwd, 0), 0);
      check("t5_fwd_lane3_held", lane(bus.d_fwd, 3), 1);
      check("t5_fwd_valid_held", longint'(bus.fwd_valid), 1);
      bus.stall    = 1'b0;
      bus.in_valid = 1'b0;
      bus.d_in     = '0;
      repeat (3) tick();
      check("t5_not_yet", longint'(bus.out_valid), 0);
      tick();
      check("t5_a_valid", longint'(bus.out_valid), 1);
      check("t5_a_dout", longint'($signed(bus.d_out)), 47);
      tick();
      check("t5_b_valid", longint'(bus.out_valid), 1);
      check("t5_b_dout", longint'($signed(bus.d_out)), 83);
      tick();
      check("t5_end", longint'(bus.out_valid), 0);

      // 6: coefficient rewrite, then clear with a vector in flight
      bus.coef_we    = 1'b1;
      bus.coef_idx   = 2'd3;
      bus.coef_wdata = 8'sd89;
      tick();
      bus.coef_we = 1'b0;
      run1("t6_coef89", 1, 1, 1, 1, 0, 1'b0, 53, 0);
      put(1, 1, 1, 1, 0, 1'b0);
      tick();
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      check("t6_clr_busy", longint'(bus.busy), 0);
      check("t6_clr_dout", longint'($signed(bus.d_out)), 0);
      seen = 1'b0;
      repeat (8) begin
         tick();
         seen |= bus.out_valid;
      end
      check("t6_clr_no_valid", longint'(seen), 0);

      // Reset mid-flight: vector lost, coefficients back to defaults
      put(1, 1, 1, 1, 0, 1'b0);
      tick();
      reset = 1'b1;
      #1;
      check("rst_mid_busy", longint'(bus.busy), 0);
      check("rst_mid_fwd_valid", longint'(bus.fwd_valid), 0);
      tick();
      reset = 1'b0;
      seen  = 1'b0;
      repeat (8) begin
         tick();
         seen |= bus.out_valid;
      end
      check("rst_mid_no_valid", longint'(seen), 0);
      run1("rst_coef_restored", 1, 1, 1, 1, 0, 1'b0, 47, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
